// File: rtl/jk_excitation_driver_if.sv
// Target-word handshake between a sequence source and jk_excitation_driver.
interface jk_excitation_driver_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/jk_excitation_driver.sv
// Queues target words and drives an external JK bank toward each, checking its Q feedback.
// Optional macro JK_TOGGLE_PREF_EN: changing bits use the toggle (j=k=1) encoding.
module jk_excitation_driver #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    jk_excitation_driver_if.slave        in_if,
    input  logic                         run,
    output logic [WIDTH-1:0]             j,
    output logic [WIDTH-1:0]             k,
    input  logic [WIDTH-1:0]             q_fb,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         busy,
    output logic                         mismatch
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LvlW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]  level_q, level_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [WIDTH-1:0] model_q, model_d;
    logic [WIDTH-1:0] bank_exp_q, bank_exp_d;
    logic             mismatch_q, mismatch_d;

    logic             push, pop;
    logic [WIDTH-1:0] head, change;

    assign in_if.in_ready = (level_q != LvlW'(DEPTH));

    always_comb begin
        push   = in_if.in_valid && in_if.in_ready;
        pop    = run && (level_q != '0);
        head   = mem_q[rd_ptr_q];
        change = model_q ^ head;

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_if.in_data;
        end
        // DEPTH is a power of two, so pointers wrap by natural overflow.
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase

        j_d     = '0;
        k_d     = '0;
        model_d = model_q;
        if (pop) begin
`ifdef JK_TOGGLE_PREF_EN
            j_d = change;
            k_d = change;
`else
            j_d = change & head;
            k_d = change & model_q;
`endif
            // Chain against the previous target, not the bank's feedback.
            model_d = head;
        end

        bank_exp_d = model_q;
        mismatch_d = mismatch_q | (q_fb != bank_exp_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            j_q        <= '0;
            k_q        <= '0;
            model_q    <= '0;
            bank_exp_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            j_q        <= j_d;
            k_q        <= k_d;
            model_q    <= model_d;
            bank_exp_q <= bank_exp_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign level    = level_q;
    assign mismatch = mismatch_q;
    assign busy     = (level_q != '0) || (j_q != '0) || (k_q != '0);

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Table-driven bench with a target scoreboard and a behavioural JK bank on the feedback path.
module tb_jk_excitation_driver;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [WIDTH-1:0] j, k, q_fb, bank_q, inj;
    logic [2:0]       level;
    logic             busy, mismatch;

    jk_excitation_driver_if #(.WIDTH(WIDTH)) in_if ();

    jk_excitation_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_if    (in_if),
        .run      (run),
        .j        (j),
        .k        (k),
        .q_fb     (q_fb),
        .level    (level),
        .busy     (busy),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    // External JK bank model
    always @(posedge clk or negedge reset) begin
        if (!reset) bank_q <= '0;
        else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({j[i], k[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end
    assign q_fb = bank_q ^ inj;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] mdl;
    logic             mm_exp;

    typedef struct {
        bit         rst;
        bit         v;
        logic [3:0] d;
        bit         r;
        int         lvl;
        bit         rdy;
        logic [3:0] bank;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit v, logic [3:0] d, bit r, int lvl, bit rdy,
                                logic [3:0] bank);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.r = r; t.lvl = lvl; t.rdy = rdy; t.bank = bank;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_task();
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        run            = 1'b0;
        inj            = '0;
        reset          = 1'b0;
        sb.delete();
        mdl    = '0;
        mm_exp = 1'b0;
        #2;
        chk("rst_level", 32'(level), 0);
        chk("rst_ready", 32'(in_if.in_ready), 1);
        chk("rst_j", 32'(j), 0);
        chk("rst_k", 32'(k), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mismatch", 32'(mismatch), 0);
        chk("rst_bank", 32'(q_fb), 0);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic r, input logic [3:0] fi);
        logic       do_push, do_pop;
        logic [3:0] t, ej, ek, eb;
        in_if.in_valid = v;
        in_if.in_data  = d;
        run            = r;
        inj            = fi;
        do_push = v && (sb.size() < DEPTH);
        do_pop  = r && (sb.size() != 0);
        @(posedge clk);
        #1;
        eb = mdl;
        ej = '0;
        ek = '0;
        if (do_pop) begin
            t = sb.pop_front();
`ifdef JK_TOGGLE_PREF_EN
            ej = mdl ^ t;
            ek = mdl ^ t;
`else
            ej = ~mdl & t;
            ek = mdl & ~t;
`endif
            mdl = t;
        end
        if (do_push) sb.push_back(d);
        if (fi != '0) mm_exp = 1'b1;
        inj = '0;
        chk("j", 32'(j), 32'(ej));
        chk("k", 32'(k), 32'(ek));
        chk("level_sb", 32'(level), 32'(sb.size()));
        chk("ready_sb", 32'(in_if.in_ready), 32'(sb.size() < DEPTH));
        chk("busy", 32'(busy), 32'((sb.size() != 0) || ej != '0 || ek != '0));
        chk("mismatch", 32'(mismatch), 32'(mm_exp));
        chk("bank", 32'(bank_q), 32'(eb));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // single push, then back-to-back A,5,F,0
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'hA, 1, 1, 1, 4'h0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'hA));
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'hA, 1, 1, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'h5, 1, 1, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'hF, 1, 1, 1, 4'hA));
        tbl.push_back(mk(0, 1, 4'h0, 1, 1, 1, 4'h5));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'hF));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h0));
        // fill with run=0, fifth word refused, then drain
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'h1, 0, 1, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'h2, 0, 2, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'h3, 0, 3, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'h4, 0, 4, 0, 4'h0));
        tbl.push_back(mk(0, 1, 4'h5, 0, 4, 0, 4'h0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 3, 1, 4'h0));
        tbl.push_back(mk(0, 0, 4'h0, 1, 2, 1, 4'h1));
        tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 4'h2));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h3));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h4));
        // full FIFO: pop with push blocked, push next cycle, order across wrap
        tbl.push_back(mk(1, 0, 4'h0, 0, 0, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'h6, 0, 1, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'h7, 0, 2, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'h8, 0, 3, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'h9, 0, 4, 0, 4'h0));
        tbl.push_back(mk(0, 1, 4'hA, 1, 3, 1, 4'h0));
        tbl.push_back(mk(0, 1, 4'hA, 1, 3, 1, 4'h6));
        tbl.push_back(mk(0, 0, 4'h0, 1, 2, 1, 4'h7));
        tbl.push_back(mk(0, 0, 4'h0, 1, 1, 1, 4'h8));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'h9));
        tbl.push_back(mk(0, 0, 4'h0, 1, 0, 1, 4'hA));

        reset = 1'b1;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        run = 1'b0;
        inj = '0;
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) reset_task();
            else begin
                step(tbl[i].v, tbl[i].d, tbl[i].r, 4'h0);
                chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
                chk("tbl_ready", 32'(in_if.in_ready), 32'(tbl[i].rdy));
                chk("tbl_bank", 32'(q_fb), 32'(tbl[i].bank));
            end
        end

        // feedback fault on bit 2 for one cycle: sticky until reset
        reset_task();
        step(1'b1, 4'hA, 1'b1, 4'h0);
        step(1'b1, 4'h5, 1'b1, 4'h0);
        step(1'b0, 4'h0, 1'b1, 4'h4);
        chk("mm_set", 32'(mismatch), 1);
        step(1'b0, 4'h0, 1'b1, 4'h0);
        step(1'b0, 4'h0, 1'b1, 4'h0);
        chk("mm_sticky", 32'(mismatch), 1);
        reset_task();

        // reset mid-sequence with level=3 and a non-zero drive in flight
        step(1'b1, 4'h1, 1'b0, 4'h0);
        step(1'b1, 4'h2, 1'b0, 4'h0);
        step(1'b1, 4'h3, 1'b0, 4'h0);
        step(1'b1, 4'h4, 1'b1, 4'h0);
        chk("pre_rst_level", 32'(level), 3);
        chk("pre_rst_j", 32'(j), 1);
        reset_task();
        step(1'b1, 4'hA, 1'b1, 4'h0);
        step(1'b1, 4'h5, 1'b1, 4'h0);
        step(1'b0, 4'h0, 1'b1, 4'h0);
        step(1'b0, 4'h0, 1'b1, 4'h0);
        step(1'b0, 4'h0, 1'b1, 4'h0);
        chk("post_rst_bank", 32'(q_fb), 32'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drives an external bank of WIDTH JK flip-flops (the team's JK_FF cells) so that it steps through a queued sequence of target states.
- Accepts target words through a valid/ready FIFO and converts each into per-bit J/K excitation against a tracked model of the bank.
- Checks the bank's Q feedback against that model every cycle and raises a sticky flag on any divergence.
- Sits between a sequence source (test controller or higher-level FSM) and the JK register bank.

Parameters:
WIDTH, 4, bits in the JK bank, target word and feedback
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
in_valid  input  1  target word offered
in_ready  output  1  FIFO can accept; equals !full
in_data  input  WIDTH  target bank state
run  input  1  1 = pop and issue when the FIFO is non-empty; 0 = hold
j  output  WIDTH  registered J drive to the bank
k  output  WIDTH  registered K drive to the bank
q_fb  input  WIDTH  Q outputs of the external bank
level  output  $clog2(DEPTH+1)  FIFO occupancy
busy  output  1  level != 0, or the last issued j/k not yet all-zero
mismatch  output  1  sticky; set on a feedback check failure

Behaviour:
- Reset (reset=0, async): FIFO empty, level=0, in_ready=1, j=0, k=0, model_q=0, bank_exp=0, mismatch=0, busy=0. The external bank must also reset to 0.
- Reset asserted mid-sequence flushes queued entries and in-flight drive with no partial pops.
- FIFO push: in_valid && in_ready at an edge writes in_data.
  - No same-cycle bypass: an entry pushed into an empty FIFO is poppable at the next edge.
- FIFO pop: run && level!=0 at an edge removes the head entry T.
- Push and pop at the same edge: both occur and level is unchanged.
  - When full, in_ready=0, so no push; a pop frees space for the next cycle only.
- Pointer wrap: read and write pointers wrap modulo DEPTH. level is tracked separately, so full and empty are never ambiguous.
- Issue on pop, per bit i with m = model_q[i], t = T[i] (default policy):
  - m=0, t=0 -> j=0, k=0
  - m=0, t=1 -> j=1, k=0
  - m=1, t=0 -> j=0, k=1
  - m=1, t=1 -> j=0, k=0
  - Same edge: model_q <= T.
- No pop (run=0 or empty): j <= 0, k <= 0 (bank holds); model_q unchanged.
- Latency:
  - pop at edge E0 -> j/k valid after E0;
  - bank samples at E1, so q_fb = T after E1;
  - minimum push-to-bank-update is 2 edges.
- Checker:
  - Every edge: bank_exp <= model_q.
  - Every edge: if q_fb != bank_exp, then mismatch <= 1.
  - mismatch stays set until reset.
  - The check is active from the first edge after reset release.
- Back-to-back pops: one target per cycle. The model chains, so each excitation is computed against the previous target, not against q_fb.
- busy drops the cycle after the last pop's j/k return to 0 with the FIFO empty.

Optional Feature:
- Macro: JK_TOGGLE_PREF_EN.
- Defined: bits that must change are driven j=1, k=1 (toggle); bits that hold stay j=0, k=0. Tests the bank's toggle path.
- Undefined: the set/reset encoding above. The bank's state sequence and all timing are identical in both builds.

Test Plan:
- Reset then push 4'hA, run=1:
  - -> after pop, j=4'hA, k=4'h0;
  - q_fb=4'hA two edges after push;
  - mismatch=0.
- Push 4'hA, 4'h5, 4'hF, 4'h0 back-to-back:
  - -> j/k sequence (A,0), (5,A), (A,0), (0,F);
  - bank reads A, 5, F, 0 on consecutive cycles.
- run=0, push 5 words with DEPTH=4:
  - -> in_ready=0 after 4 pushes, level=4, 5th word not accepted, j=k=0.
  - Then run=1 -> 4 pops, level counts 3, 2, 1, 0.
- Full FIFO with simultaneous pop and push offered:
  - -> pop occurs, push blocked that cycle, accepted next cycle;
  - data order preserved across pointer wrap.
- Force q_fb bit 2 inverted for one cycle while running:
  - -> mismatch=1 next edge and stays 1 with correct feedback;
  - reset pulse -> mismatch=0.
- Assert reset mid-sequence with level=3:
  - -> level=0, j=k=0, bank_exp=0 immediately;
  - after release, new pushes start from model 0.
  - With JK_TOGGLE_PREF_EN, pushing 4'hA, then 4'h5 -> j=k=4'hA, then j=k=4'hF.
